rggen_bit_field_initiator: RTL
==============================

# rggen_bit_field_initiator

Access initiator for the software side of a single bit field. Accepts read, write, set-bits and clear-bits commands over a valid/ready channel and drives the field's strobe, mask and data signals. Returns the captured read data on a valid/ready response channel. Sits between a host adapter or test sequencer and one bit field, and drives the same valid / read_mask / write_mask / write_data / read_data signal set that a bit field consumes.

## Interface
- WIDTH, 8, field width in bits.
- i_clk  input  1  clock.
- i_rst_n  input  1  reset. One clock; reset is asynchronous and active-low.
- i_cmd_valid  input  1  command present.
- o_cmd_ready  output  1  command accepted when high together with i_cmd_valid.
- i_cmd_op  input  2  opcode: 0 READ, 1 WRITE, 2 SET_BITS, 3 CLEAR_BITS.
- i_cmd_mask  input  WIDTH  per-bit access mask.
- i_cmd_data  input  WIDTH  write data, or set/clear pattern.
- o_field_valid  output  1  one-cycle access strobe.
- o_field_read_mask  output  WIDTH  read mask for the access.
- o_field_write_mask  output  WIDTH  write mask for the access.
- o_field_write_data  output  WIDTH  write data for the access.
- i_field_read_data  input  WIDTH  field read data; combinational and valid in the strobe cycle.
- o_rsp_valid  output  1  response present.
- i_rsp_ready  input  1  response consumed.
- o_rsp_data  output  WIDTH  response data.
- o_busy  output  1  high in any state other than IDLE.

## Operation
- States: IDLE, PEEK, ACCESS, RESP.
- IDLE
  - o_cmd_ready=1.
  - On handshake, latch op, mask and data.
  - READ/WRITE go to ACCESS; SET_BITS/CLEAR_BITS go to PEEK.
- PEEK
  - o_field_valid=1 with both masks '0. No field side effect occurs, including on read-clear and read-set fields.
  - Capture i_field_read_data into the peek register, then go to ACCESS.
- ACCESS (o_field_valid=1), then go to RESP:
  - READ: read_mask=mask, write_mask='0. Capture i_field_read_data as the response.
  - WRITE: write_mask=mask, write_data=data. Response is '0.
  - SET_BITS: write_mask=mask, write_data=peek | data. Response is the peek value.
  - CLEAR_BITS: write_mask=mask, write_data=peek & ~data. Response is the peek value.
- RESP
  - o_rsp_valid=1, o_rsp_data held stable.
  - When i_rsp_ready=1, go to IDLE.
- Outside PEEK and ACCESS: o_field_valid=0, both masks '0, o_field_write_data='0.
- A zero i_cmd_mask is legal. The access is still issued with zero masks and has no effect.
- Unmasked write_data bits are don't-care to the field but are driven as computed above.
- Only one command is in flight at a time. There is no pipelining.

## Timing
- Reset values: state IDLE; o_cmd_ready=1; o_busy=0; o_field_valid=0; all mask/data outputs '0; o_rsp_valid=0; o_rsp_data='0.
- Command handshake in cycle T:
  - READ/WRITE: field strobe at T+1, o_rsp_valid from T+2.
  - SET_BITS/CLEAR_BITS: peek at T+1, write at T+2, o_rsp_valid from T+3.
- Response handshake in cycle R: o_cmd_ready=1 at R+1. A new command handshake occurs at R+1 at the earliest.
- o_rsp_valid stays high and o_rsp_data stays stable until the handshake.
- Reset asserted mid-operation: all outputs return to their reset values immediately. Any in-flight access and response are dropped; no partial write is completed after reset.
- All field outputs are registered. i_field_read_data is sampled only at the clock edge that ends PEEK or ACCESS.

## Structure
- Add typedef enum logic [1:0] rggen_field_op (RGGEN_FIELD_READ, RGGEN_FIELD_WRITE, RGGEN_FIELD_SET_BITS, RGGEN_FIELD_CLEAR_BITS) to rggen_rtl_pkg.
- Add the state enum to rggen_rtl_pkg as well.
- No sub-module: one FSM, a command register, a peek register and a response register.
- The bench pairs this block with a rggen_bit_field instance connected through rggen_bit_field_if.

## Test plan
All scenarios use WIDTH=8 and a default read/write field with INITIAL_VALUE 8'h5A, unless stated otherwise.
- Reset → all outputs at reset values. READ mask 8'hFF → o_field_valid only at T+1; response 8'h5A at T+2.
- WRITE data 8'hC3 mask 8'h0F, then READ → response 8'h53. Strobe cycle shows write_mask 8'h0F and write_data 8'hC3.
- SET_BITS data 8'h81 mask 8'hFF on 8'h5A → PEEK has both masks zero; ACCESS write_data 8'hDB; response 8'h5A; field reads 8'hDB. CLEAR_BITS data 8'h0F → field reads 8'hD0.
- Field with read-clear action holding 8'h33: SET_BITS data 8'h04 → PEEK does not clear the field; field ends at 8'h37. A plain READ then returns 8'h37 and clears the field to 8'h00.
- Back-pressure: i_rsp_ready low for 5 cycles → o_rsp_valid and data stable, o_cmd_ready=0, no extra field strobe. Release → o_cmd_ready=1 the next cycle.
- Assert i_rst_n low during PEEK of CLEAR_BITS → no ACCESS strobe; field keeps its value; block is idle with reset outputs after release.

Source files
------------

// File: rtl/rggen_rtl_pkg.sv
// Shared types for the rggen RTL slice: bit-field access opcodes and the
// software-side initiator state encoding.
package rggen_rtl_pkg;

  localparam int unsigned RGGEN_FIELD_OP_WIDTH = 2;

  typedef enum logic [RGGEN_FIELD_OP_WIDTH-1:0] {
    RGGEN_FIELD_READ       = 2'd0,
    RGGEN_FIELD_WRITE      = 2'd1,
    RGGEN_FIELD_SET_BITS   = 2'd2,
    RGGEN_FIELD_CLEAR_BITS = 2'd3
  } rggen_field_op;

  typedef enum logic [1:0] {
    RGGEN_INIT_IDLE   = 2'd0,
    RGGEN_INIT_PEEK   = 2'd1,
    RGGEN_INIT_ACCESS = 2'd2,
    RGGEN_INIT_RESP   = 2'd3
  } rggen_initiator_state;

endpackage

// File: rtl/rggen_bit_field_initiator.sv
// Software-side access initiator for one bit field: turns read/write/set/clear
// commands into field strobes and returns the captured data as a response.
module rggen_bit_field_initiator
  import rggen_rtl_pkg::*;
#(
  parameter int unsigned WIDTH = 8
)(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [1:0]       i_cmd_op,
  input  logic [WIDTH-1:0] i_cmd_mask,
  input  logic [WIDTH-1:0] i_cmd_data,
  output logic             o_field_valid,
  output logic [WIDTH-1:0] o_field_read_mask,
  output logic [WIDTH-1:0] o_field_write_mask,
  output logic [WIDTH-1:0] o_field_write_data,
  input  logic [WIDTH-1:0] i_field_read_data,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [WIDTH-1:0] o_rsp_data,
  output logic             o_busy
);

  rggen_initiator_state state_q, state_d;
  rggen_field_op        op_q, op_d;
  logic [WIDTH-1:0]     mask_q, mask_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic [WIDTH-1:0]     peek_q, peek_d;
  logic [WIDTH-1:0]     rsp_d;

  logic             cmd_ready_d;
  logic             busy_d;
  logic             field_valid_d;
  logic [WIDTH-1:0] read_mask_d;
  logic [WIDTH-1:0] write_mask_d;
  logic [WIDTH-1:0] write_data_d;
  logic             rsp_valid_d;

  // Next state, command/peek/response capture, and next registered outputs.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    mask_d  = mask_q;
    data_d  = data_q;
    peek_d  = peek_q;
    rsp_d   = o_rsp_data;

    case (state_q)
      RGGEN_INIT_IDLE: begin
        if (i_cmd_valid) begin
          op_d   = rggen_field_op'(i_cmd_op);
          mask_d = i_cmd_mask;
          data_d = i_cmd_data;
          if ((op_d == RGGEN_FIELD_READ) || (op_d == RGGEN_FIELD_WRITE)) begin
            state_d = RGGEN_INIT_ACCESS;
          end else begin
            state_d = RGGEN_INIT_PEEK;
          end
        end
      end
      RGGEN_INIT_PEEK: begin
        peek_d  = i_field_read_data;
        state_d = RGGEN_INIT_ACCESS;
      end
      RGGEN_INIT_ACCESS: begin
        case (op_q)
          RGGEN_FIELD_READ:  rsp_d = i_field_read_data;
          RGGEN_FIELD_WRITE: rsp_d = '0;
          default:           rsp_d = peek_q;
        endcase
        state_d = RGGEN_INIT_RESP;
      end
      RGGEN_INIT_RESP: begin
        if (i_rsp_ready) begin
          state_d = RGGEN_INIT_IDLE;
        end
      end
      default: state_d = RGGEN_INIT_IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    cmd_ready_d   = (state_d == RGGEN_INIT_IDLE);
    busy_d        = (state_d != RGGEN_INIT_IDLE);
    field_valid_d = (state_d == RGGEN_INIT_PEEK) || (state_d == RGGEN_INIT_ACCESS);
    rsp_valid_d   = (state_d == RGGEN_INIT_RESP);
    read_mask_d   = '0;
    write_mask_d  = '0;
    write_data_d  = '0;
    if (state_d == RGGEN_INIT_ACCESS) begin
      case (op_d)
        RGGEN_FIELD_READ: begin
          read_mask_d = mask_d;
        end
        RGGEN_FIELD_WRITE: begin
          write_mask_d = mask_d;
          write_data_d = data_d;
        end
        RGGEN_FIELD_SET_BITS: begin
          write_mask_d = mask_d;
          write_data_d = peek_d | data_d;
        end
        default: begin
          write_mask_d = mask_d;
          write_data_d = peek_d & ~data_d;
        end
      endcase
    end
  end

  // State and captured command/peek registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= RGGEN_INIT_IDLE;
      op_q    <= RGGEN_FIELD_READ;
      mask_q  <= '0;
      data_q  <= '0;
      peek_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      mask_q  <= mask_d;
      data_q  <= data_d;
      peek_q  <= peek_d;
    end
  end

  // Output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_cmd_ready        <= 1'b1;
      o_busy             <= 1'b0;
      o_field_valid      <= 1'b0;
      o_field_read_mask  <= '0;
      o_field_write_mask <= '0;
      o_field_write_data <= '0;
      o_rsp_valid        <= 1'b0;
      o_rsp_data         <= '0;
    end else begin
      o_cmd_ready        <= cmd_ready_d;
      o_busy             <= busy_d;
      o_field_valid      <= field_valid_d;
      o_field_read_mask  <= read_mask_d;
      o_field_write_mask <= write_mask_d;
      o_field_write_data <= write_data_d;
      o_rsp_valid        <= rsp_valid_d;
      o_rsp_data         <= rsp_d;
    end
  end

endmodule
